camasir_besleyici: RTL and testbench

- Initiator side of the basla/bitti laundry handshake. It queues incoming laundry batches and issues them one at a time to the downstream laundry pipeline (washing→drying→folding→placement).
- For each batch it drives `camasir` and a one-cycle `basla` pulse, then waits for the pipeline's `bitti` before issuing the next batch.
- A timeout watchdog flags a pipeline that never finishes.
- Sits between the batch source and the laundry system top.

---
 rtl/camasir_besleyici.sv | 136 +++++++++++++
 tb/tb_camasir_besleyici.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camasir_besleyici.sv
// camasir_besleyici: initiator side of the basla/bitti laundry handshake.
// Queues incoming laundry batches and hands them one at a time to the
// downstream laundry pipeline, waiting for completion before the next one.
// A watchdog flags a pipeline that never reports completion.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   giris_camasir  batch to enqueue
//   giris_gecerli  giris_camasir valid this cycle
//   giris_hazir    queue can accept (not full)
//   camasir        batch presented to the pipeline
//   basla          one-cycle start pulse to the pipeline
//   bitti          pipeline completion pulse
//   mesgul         a batch is outstanding
//   hata           sticky timeout error
//   tamamlanan     completed-batch count, wraps modulo 256
module camasir_besleyici #(
  parameter int W       = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] giris_camasir,
  input  logic         giris_gecerli,
  output logic         giris_hazir,
  output logic [W-1:0] camasir,
  output logic         basla,
  input  logic         bitti,
  output logic         mesgul,
  output logic         hata,
  output logic [7:0]   tamamlanan
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  WD_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {BOS, BASLAT, BEKLE, HATA} state_t;

  state_t         state, state_d;
  logic [W-1:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic [7:0]     wd, wd_d, tam_d;
  logic           hata_d, basla_d;
  logic           push, pop;

  // Readiness comes from registered occupancy only: a pop in the same cycle
  // does not open a slot for a push while full.
  assign giris_hazir = (count != FULL_CNT);
  assign push        = giris_gecerli && giris_hazir;
  assign mesgul      = (state == BASLAT) || (state == BEKLE);

  always_comb begin
    state_d = state;
    wd_d    = wd;
    tam_d   = tamamlanan;
    hata_d  = hata;
    basla_d = 1'b0;
    pop     = 1'b0;
    case (state)
      BOS: begin
        if (count != '0) begin
          pop     = 1'b1;
          basla_d = 1'b1;
          state_d = BASLAT;
        end
      end
      BASLAT: begin
        wd_d    = '0;
        state_d = BEKLE;
      end
      BEKLE: begin
        // Completion is checked first so a bitti on the expiry cycle wins.
        if (bitti) begin
          tam_d   = tamamlanan + 8'd1;
          state_d = BOS;
        end else if (wd == WD_LAST) begin
          hata_d  = 1'b1;
          state_d = HATA;
        end else begin
          wd_d = wd + 8'd1;
        end
      end
      HATA: begin
        hata_d = 1'b1;
      end
      default: begin
        state_d = BOS;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOS;
      wd         <= '0;
      tamamlanan <= '0;
      hata       <= 1'b0;
      basla      <= 1'b0;
      camasir    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_d;
      wd         <= wd_d;
      tamamlanan <= tam_d;
      hata       <= hata_d;
      basla      <= basla_d;
      if (pop) begin
        camasir <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= giris_camasir;
    end
  end

endmodule

// File: tb/tb_camasir_besleyici.sv
module tb_camasir_besleyici;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int TO    = 10;

  logic          clk;
  logic          rst;
  logic [W-1:0]  giris_camasir;
  logic          giris_gecerli;
  logic          giris_hazir;
  logic [W-1:0]  camasir;
  logic          basla;
  logic          bitti;
  logic          mesgul;
  logic          hata;
  logic [7:0]    tamamlanan;

  camasir_besleyici #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .giris_camasir (giris_camasir),
    .giris_gecerli (giris_gecerli),
    .giris_hazir   (giris_hazir),
    .camasir       (camasir),
    .basla         (basla),
    .bitti         (bitti),
    .mesgul        (mesgul),
    .hata          (hata),
    .tamamlanan    (tamamlanan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a batch queue plus the life of the outstanding batch.
  logic [W-1:0] m_q[$];
  logic [W-1:0] exp_q[$];
  bit           m_busy;      // batch handed out, not yet finished
  bit           m_started;   // start pulse is visible this cycle
  int           m_waited;    // cycles already spent waiting for completion
  bit           m_err;
  logic [W-1:0] m_cam;
  logic [7:0]   m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    bit hz;
    logic [W-1:0] d;
    if (rst) begin
      m_q.delete();
      m_busy = 0; m_started = 0; m_waited = 0; m_err = 0;
      m_cam = '0; m_cnt = '0;
      return;
    end
    hz = (m_q.size() < DEPTH);
    if (m_err) begin
      // stuck until reset
    end else if (!m_busy) begin
      if (m_q.size() > 0) begin
        d = m_q.pop_front();
        m_cam = d;
        m_busy = 1;
        m_started = 1;
        exp_q.push_back(d);
      end
    end else if (m_started) begin
      m_started = 0;
      m_waited  = 0;
    end else if (bitti) begin
      m_cnt  = m_cnt + 8'd1;
      m_busy = 0;
    end else if (m_waited == TO - 1) begin
      m_err  = 1;
      m_busy = 0;
    end else begin
      m_waited++;
    end
    if (giris_gecerli && hz) m_q.push_back(giris_camasir);
  endtask

  task automatic check_outputs();
    chk("giris_hazir", {31'b0, giris_hazir}, {31'b0, (m_q.size() < DEPTH)});
    chk("basla",       {31'b0, basla},       {31'b0, m_started});
    chk("mesgul",      {31'b0, mesgul},      {31'b0, m_busy});
    chk("hata",        {31'b0, hata},        {31'b0, m_err});
    chk("tamamlanan",  {24'b0, tamamlanan},  {24'b0, m_cnt});
    chk("camasir",     {16'b0, camasir},     {16'b0, m_cam});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1; giris_gecerli = 0; bitti = 0;
    tick();
    rst = 0;
  endtask

  // Tick until the model says the outstanding batch is waiting for bitti.
  task automatic wait_bekle();
    for (int i = 0; i < 20; i++) begin
      if (m_busy && !m_started) return;
      tick();
    end
    chk("wait_bekle_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_batch(input logic [W-1:0] d, input int delay);
    giris_gecerli = 1; giris_camasir = d;
    tick();
    giris_gecerli = 0;
    wait_bekle();
    repeat (delay) tick();
    bitti = 1;
    tick();
    bitti = 0;
  endtask

  // Scoreboard monitor: every start pulse must carry the next expected batch.
  always @(negedge clk) begin
    if (basla === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_basla: got camasir %0h expected no start", camasir);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (camasir !== e) begin
          n_fail++;
          $display("FAIL sb_order: got camasir %0h expected %0h", camasir, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1; giris_gecerli = 0; giris_camasir = '0; bitti = 0;
    do_reset();
    do_reset();
    chk("reset_hazir", {31'b0, giris_hazir}, 32'd1);
    chk("reset_cam",   {16'b0, camasir},     32'd0);

    // Single batch, completion five cycles after the start pulse
    giris_gecerli = 1; giris_camasir = 16'hA5A5;
    tick();
    giris_gecerli = 0;
    tick();
    chk("single_basla", {31'b0, basla}, 32'd1);
    chk("single_cam",   {16'b0, camasir}, 32'h0000A5A5);
    repeat (4) tick();
    bitti = 1;
    tick();
    bitti = 0;
    tick();
    chk("single_cnt",    {24'b0, tamamlanan}, 32'd1);
    chk("single_mesgul", {31'b0, mesgul},     32'd0);
    chk("single_hold",   {16'b0, camasir},    32'h0000A5A5);

    // Ordering and full queue with a stalled pipeline
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      giris_gecerli = 1; giris_camasir = W'(i);
      tick();
    end
    giris_gecerli = 0;
    chk("full_hazir", {31'b0, giris_hazir}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      wait_bekle();
      bitti = 1;
      tick();
      bitti = 0;
    end
    repeat (3) tick();
    chk("order_cnt", {24'b0, tamamlanan}, 32'd5);

    // Timeout, then pushes while in error, then reset
    do_reset();
    giris_gecerli = 1; giris_camasir = 16'h1234;
    tick();
    giris_gecerli = 0;
    repeat (TO + 3) tick();
    chk("timeout_hata", {31'b0, hata}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      giris_gecerli = 1; giris_camasir = W'($urandom);
      tick();
    end
    giris_gecerli = 0;
    repeat (4) tick();
    do_reset();
    repeat (3) tick();
    chk("timeout_clr", {31'b0, hata}, 32'd0);

    // Completion on the last permitted waiting cycle
    giris_gecerli = 1; giris_camasir = 16'hBEEF;
    tick();
    giris_gecerli = 0;
    tick();
    repeat (TO) tick();
    bitti = 1;
    tick();
    bitti = 0;
    tick();
    chk("tie_hata", {31'b0, hata},       32'd0);
    chk("tie_cnt",  {24'b0, tamamlanan}, 32'd1);

    // Spurious and wide bitti
    do_reset();
    bitti = 1;
    tick();
    bitti = 0;
    giris_gecerli = 1; giris_camasir = 16'h0C0C;
    tick();
    giris_gecerli = 0;
    bitti = 1;
    tick();
    bitti = 0;
    repeat (2) tick();
    bitti = 1;
    tick();
    bitti = 0;
    giris_gecerli = 1; giris_camasir = 16'h0D0D;
    tick();
    giris_gecerli = 0;
    wait_bekle();
    bitti = 1;
    repeat (3) tick();
    bitti = 0;
    repeat (2) tick();
    chk("spurious_cnt", {24'b0, tamamlanan}, 32'd2);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      giris_gecerli = 1'($urandom_range(0, 1));
      giris_camasir = W'($urandom);
      bitti         = ($urandom_range(0, 3) == 0);
      rst           = (m_err && $urandom_range(0, 7) == 0) || ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0; giris_gecerli = 0; bitti = 0;

    // Counter wrap, then reset while waiting with batches queued
    do_reset();
    for (int i = 0; i < 256; i++) run_batch(W'(i * 7 + 3), 0);
    tick();
    chk("wrap_cnt", {24'b0, tamamlanan}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      giris_gecerli = 1; giris_camasir = W'(16'h7000 + i);
      tick();
    end
    giris_gecerli = 0;
    wait_bekle();
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_mesgul", {31'b0, mesgul},      32'd0);
    chk("midrst_cam",    {16'b0, camasir},     32'd0);
    chk("midrst_hazir",  {31'b0, giris_hazir}, 32'd1);
    repeat (5) tick();
    chk("midrst_basla",  {31'b0, basla},       32'd0);

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
